// File: rtl/bus_device_if.sv
// Bus interface for bus_device: read/write strobe, address, write data,
// registered read data and the sticky error flag.
// Ports: master drives r_wn/addr/wdata; slave drives rdata/err.
interface bus_device_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  r_wn;   // 1 = read or idle, 0 = write
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output r_wn, addr, wdata,
    input  rdata, err
  );

  modport slave (
    input  r_wn, addr, wdata,
    output rdata, err
  );
endinterface

// File: rtl/bus_device.sv
// Two-window register file on a simple strobe bus; out-of-range writes set a sticky error.
// Latency: write commits on the first low cycle of r_wn; read data is registered, 1 cycle.
// Backpressure: none; one write per low pulse of r_wn, rdata holds while r_wn is low.
// Ports: clk, rst (sync, active-high), bus (bus_device_if.slave),
//        wr_count/oor_count (16-bit saturating) only when BUS_DEVICE_STATS_EN is defined.
module bus_device #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RANGE0_LO  = 0,
  parameter int RANGE0_HI  = 16,
  parameter int RANGE1_LO  = 32,
  parameter int RANGE1_HI  = 48
) (
  input  logic         clk,
  input  logic         rst,
  bus_device_if.slave  bus
`ifdef BUS_DEVICE_STATS_EN
  ,
  output logic [15:0]  wr_count,
  output logic [15:0]  oor_count
`endif
);

  localparam int W0    = RANGE0_HI - RANGE0_LO;
  localparam int W1    = RANGE1_HI - RANGE1_LO;
  localparam int DEPTH = W0 + W1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    WR_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic                  commit;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  // Window decode on the zero-extended address. Subtracting the lower bound and
  // comparing unsigned against the window size covers both bounds at once
  // (addresses below the window wrap to large values), so nothing aliases.
  logic [31:0]      addr_ext;
  logic [31:0]      off0, off1;
  logic             in_win0, in_win1, in_range;
  logic [IDX_W-1:0] idx;

  assign addr_ext = 32'(bus.addr);
  assign off0     = addr_ext - 32'(RANGE0_LO);
  assign off1     = addr_ext - 32'(RANGE1_LO);
  assign in_win0  = off0 < 32'(W0);
  assign in_win1  = off1 < 32'(W1);
  assign in_range = in_win0 | in_win1;
  // Window 1 words sit directly after window 0 in storage.
  assign idx      = in_win0 ? IDX_W'(off0) : IDX_W'(32'(W0) + off1);

  // Write FSM: a commit happens only on the IDLE -> WR_HOLD step, so a long
  // low pulse on r_wn still produces exactly one write.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.r_wn) begin
          state_d = WR_HOLD;
          commit  = 1'b1;
        end
      end
      WR_HOLD: begin
        if (bus.r_wn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        if (in_range) mem[idx] <= bus.wdata;
        else          err_q    <= 1'b1;
      end
      // Reads see storage as of this edge, so a read the cycle after a
      // commit returns the new word.
      if (bus.r_wn) rdata_q <= in_range ? mem[idx] : '0;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

`ifdef BUS_DEVICE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count  <= '0;
      oor_count <= '0;
    end else if (commit) begin
      if (in_range) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (oor_count != 16'hFFFF) oor_count <= oor_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_device.sv
// Self-checking bench for bus_device: scoreboard of expected read data,
// reference memory model indexed by raw address, sticky-error and counter model.
module tb_bus_device;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_device_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

`ifdef BUS_DEVICE_STATS_EN
  logic [15:0] wr_count, oor_count;
`endif

  bus_device dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BUS_DEVICE_STATS_EN
    ,
    .wr_count  (wr_count),
    .oor_count (oor_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] model [256];
  logic       model_err;
  int         model_wr, model_oor;
  logic [7:0] sb [$];
  logic [7:0] exp_d;

  function automatic bit tb_in_range(input int a);
    return ((a >= 0) && (a < 16)) || ((a >= 32) && (a < 48));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    model_err = 1'b0;
    model_wr  = 0;
    model_oor = 0;
  endtask

  task automatic model_commit(input int a, input logic [7:0] d);
    if (tb_in_range(a)) begin
      model[a] = d;
      model_wr++;
    end else begin
      model_err = 1'b1;
      model_oor++;
    end
  endtask

  // One-cycle low pulse on r_wn, then one cycle high to return the FSM to IDLE.
  task automatic write_pulse(input int a, input logic [7:0] d);
    bus.r_wn  = 1'b0;
    bus.addr  = 8'(a);
    bus.wdata = d;
    cyc();
    model_commit(a, d);
    bus.r_wn = 1'b1;
    cyc();
  endtask

  // Drive a read and push its expected data; the caller pops after the edge.
  task automatic drive_read(input int a);
    bus.r_wn = 1'b1;
    bus.addr = 8'(a);
    sb.push_back(tb_in_range(a) ? model[a] : 8'h00);
    cyc();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.r_wn  = 1'b1;
    bus.addr  = 8'h00;
    bus.wdata = 8'h00;
    do_reset(2);
    checks++;
    if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h want=00", bus.rdata); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", bus.err); end
`ifdef BUS_DEVICE_STATS_EN
    checks++;
    if (wr_count !== 16'd0 || oor_count !== 16'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", wr_count, oor_count);
    end
`endif
  endtask

  task automatic test_basic_rw();
    write_pulse(5, 8'h06);
    drive_read(5);
    exp_d = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_d) begin errors++; $display("FAIL basic_read got=%h want=%h", bus.rdata, exp_d); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b want=0", bus.err); end
  endtask

  task automatic test_hold_write();
    logic [7:0] seq [4];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_read(5);
    exp_d = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_d) begin errors++; $display("FAIL hold_preread got=%h want=%h", bus.rdata, exp_d); end
    bus.r_wn = 1'b0;
    bus.addr = 8'd40;
    for (int i = 0; i < 4; i++) begin
      bus.wdata = seq[i];
      cyc();
      if (i == 0) model_commit(40, seq[0]);
      checks++;
      if (bus.rdata !== exp_d) begin errors++; $display("FAIL hold_rdata_stable cyc=%0d got=%h want=%h", i, bus.rdata, exp_d); end
    end
    bus.r_wn = 1'b1;
    cyc();
    drive_read(40);
    exp_d = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_d) begin errors++; $display("FAIL hold_word40 got=%h want=%h", bus.rdata, exp_d); end
`ifdef BUS_DEVICE_STATS_EN
    checks++;
    if (wr_count !== 16'(model_wr)) begin errors++; $display("FAIL hold_wr_count got=%0d want=%0d", wr_count, model_wr); end
`endif
  endtask

  task automatic test_oor();
    int rd [3];
    rd = '{20, 133, 5};
    bus.r_wn  = 1'b0;
    bus.addr  = 8'd20;
    bus.wdata = 8'h55;
    cyc();
    model_commit(20, 8'h55);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_err_set got=%b want=1", bus.err); end
    bus.r_wn = 1'b1;
    cyc();
    write_pulse(6, 8'h66);
    checks++;
    if (bus.err !== model_err) begin errors++; $display("FAIL oor_err_sticky got=%b want=%b", bus.err, model_err); end
    // 133 would alias onto 5 if the decode dropped the top address bit.
    foreach (rd[i]) begin
      drive_read(rd[i]);
      exp_d = sb.pop_front();
      checks++;
      if (bus.rdata !== exp_d) begin errors++; $display("FAIL oor_read addr=%0d got=%h want=%h", rd[i], bus.rdata, exp_d); end
    end
`ifdef BUS_DEVICE_STATS_EN
    checks++;
    if (oor_count !== 16'(model_oor)) begin errors++; $display("FAIL oor_count got=%0d want=%0d", oor_count, model_oor); end
`endif
  endtask

  task automatic test_boundaries();
    int rd [6];
    rd = '{16, 32, 15, 47, 31, 48};
    write_pulse(15, 8'hAA);
    write_pulse(47, 8'hBB);
    write_pulse(16, 8'hC1);
    write_pulse(32, 8'hC2);
    write_pulse(48, 8'hC3);
    foreach (rd[i]) begin
      drive_read(rd[i]);
      exp_d = sb.pop_front();
      checks++;
      if (bus.rdata !== exp_d) begin errors++; $display("FAIL boundary_read addr=%0d got=%h want=%h", rd[i], bus.rdata, exp_d); end
    end
  endtask

  task automatic test_back_to_back();
    int         ad [2];
    logic [7:0] dd [2];
    ad = '{10, 33};
    dd = '{8'h5A, 8'hC3};
    for (int i = 0; i < 2; i++) begin
      bus.r_wn  = 1'b0;
      bus.addr  = 8'(ad[i]);
      bus.wdata = dd[i];
      cyc();
      model_commit(ad[i], dd[i]);
      drive_read(ad[i]);
      exp_d = sb.pop_front();
      checks++;
      if (bus.rdata !== exp_d) begin errors++; $display("FAIL b2b_read addr=%0d got=%h want=%h", ad[i], bus.rdata, exp_d); end
    end
  endtask

  task automatic test_reset_in_hold();
    bus.r_wn  = 1'b0;
    bus.addr  = 8'd3;
    bus.wdata = 8'h11;
    cyc();
    model_commit(3, 8'h11);
    bus.wdata = 8'h7E;
    rst = 1'b1;
    cyc();
    cyc();
    model_clear();
    checks++;
    if (bus.err !== 1'b0 || bus.rdata !== 8'h00) begin
      errors++; $display("FAIL rst_hold_outputs got=%b/%h want=0/00", bus.err, bus.rdata);
    end
    rst = 1'b0;
    cyc();
    model_commit(3, 8'h7E);
    bus.r_wn = 1'b1;
    cyc();
    for (int a = 0; a < 48; a++) begin
      drive_read(a);
      exp_d = sb.pop_front();
      checks++;
      if (bus.rdata !== exp_d) begin errors++; $display("FAIL rst_hold_word addr=%0d got=%h want=%h", a, bus.rdata, exp_d); end
    end
`ifdef BUS_DEVICE_STATS_EN
    checks++;
    if (wr_count !== 16'(model_wr) || oor_count !== 16'(model_oor)) begin
      errors++; $display("FAIL rst_hold_counters got=%0d/%0d want=%0d/%0d", wr_count, oor_count, model_wr, model_oor);
    end
`endif
  endtask

  task automatic test_sweep();
    do_reset(1);
    for (int a = 0; a < 256; a++)
      if (tb_in_range(a)) write_pulse(a, 8'(a + 1));
    for (int a = 0; a < 256; a++) begin
      if (tb_in_range(a)) begin
        drive_read(a);
        exp_d = sb.pop_front();
        checks++;
        if (bus.rdata !== exp_d) begin errors++; $display("FAIL sweep_read addr=%0d got=%h want=%h", a, bus.rdata, exp_d); end
      end
    end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL sweep_err got=%b want=0", bus.err); end
`ifdef BUS_DEVICE_STATS_EN
    checks++;
    if (wr_count !== 16'd32) begin errors++; $display("FAIL sweep_wr_count got=%0d want=32", wr_count); end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    bus.r_wn  = 1'b1;
    bus.addr  = 8'h00;
    bus.wdata = 8'h00;
    model_clear();
    test_reset();
    test_basic_rw();
    test_hold_write();
    test_oor();
    test_boundaries();
    test_back_to_back();
    test_reset_in_hold();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_device.md
BUS_DEVICE -- requirements
Module: bus_device

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 8, address bus width.
- DATA_WIDTH, 8, data bus width.
- RANGE0_LO, 0, first valid window, inclusive lower bound.
- RANGE0_HI, 16, first valid window, exclusive upper bound.
- RANGE1_LO, 32, second valid window, inclusive lower bound.
- RANGE1_HI, 48, second valid window, exclusive upper bound.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- r_wn, input, 1, bus strobe: 1 = read or idle, 0 = write.
- addr, input, ADDR_WIDTH, access address.
- wdata, input, DATA_WIDTH, write data.
- rdata, output, DATA_WIDTH, registered read data.
- err, output, 1, sticky error flag for out-of-range writes.
- wr_count, output, 16, committed-write counter; present only with BUS_DEVICE_STATS_EN.
- oor_count, output, 16, out-of-range write counter; present only with BUS_DEVICE_STATS_EN.

REQ-003 There SHALL be one clock, clk; reset, rst, SHALL be synchronous and active-high.

Function
REQ-004 An address a SHALL be in range iff (RANGE0_LO <= a < RANGE0_HI) or (RANGE1_LO <= a < RANGE1_HI).
REQ-005 Storage SHALL hold exactly (RANGE0_HI-RANGE0_LO)+(RANGE1_HI-RANGE1_LO) words, mapped as follows:
- Window 0: index = a-RANGE0_LO.
- Window 1: index = (RANGE0_HI-RANGE0_LO)+(a-RANGE1_LO).
REQ-006 The write FSM SHALL have states IDLE and WR_HOLD.
- IDLE -> WR_HOLD when r_wn=0 is sampled.
- WR_HOLD -> IDLE when r_wn=1 is sampled.
REQ-007 A write SHALL commit only on the IDLE->WR_HOLD transition.
- Exactly one write is committed per low pulse, regardless of how long r_wn is held low.
- addr and wdata are sampled in that cycle.
REQ-008 A committed write to an in-range address SHALL update the mapped word.
REQ-009 A committed write to an out-of-range address SHALL leave storage unchanged and set err to 1 at the next edge.
REQ-010 When r_wn=1 is sampled, rdata SHALL load at the next edge:
- the mapped word if addr is in range;
- 0 if addr is out of range.
The read latency is one cycle.
REQ-011 When r_wn=0 is sampled, rdata SHALL hold its value.
REQ-012 A read sampled in the cycle after a write commit, at the same address, SHALL return the newly written data.
REQ-013 err SHALL remain 1 until reset; further errors have no additional effect.
REQ-014 Address windows SHALL be decoded with full ADDR_WIDTH comparisons; there is no aliasing or wrap of addresses outside the windows.

Reset
REQ-015 While rst=1 is sampled, at each edge the block SHALL:
- set rdata=0 and err=0;
- set the FSM to IDLE;
- clear every storage word to 0;
- clear the counters when present.
REQ-016 Bus inputs SHALL be ignored while rst=1 is sampled; no write commits in that cycle.
REQ-017 If rst rises while the FSM is in WR_HOLD, the FSM SHALL return to IDLE.
- If r_wn is still 0 in the first cycle after reset deasserts, one write SHALL commit in that cycle.

Configuration
REQ-018 With macro BUS_DEVICE_STATS_EN defined, the block SHALL provide wr_count and oor_count.
- wr_count increments by 1 on every in-range committed write.
- oor_count increments by 1 on every out-of-range committed write.
- Both saturate at 16'hFFFF.
REQ-019 Without BUS_DEVICE_STATS_EN, the ports wr_count and oor_count and their logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-020 Reset, then write addr=5, wdata=6 (r_wn low for 1 cycle), then read addr=5 -> rdata=6 one cycle after the read is sampled; err=0.
REQ-021 Hold r_wn=0 for 4 cycles at addr=40 while wdata changes 0x11, 0x22, 0x33, 0x44 -> word 40 = 0x11; wr_count=1 with stats enabled.
REQ-022 Write addr=20, wdata=0x55 (out of range) -> err=1 the next cycle and stays 1; reading addr=20 -> rdata=0; oor_count=1.
REQ-023 Write addr=15 and addr=47 with 0xAA and 0xBB; read addr=16 and addr=32 -> 0 and 0; read addr=15 and addr=47 -> 0xAA and 0xBB (window boundaries).
REQ-024 Assert rst while in WR_HOLD with r_wn=0 at addr=3, wdata=0x7E; deassert rst while r_wn is still 0 -> word 3 = 0x7E after reset; all other words = 0.
REQ-025 Run the host-style sweep (write i+1 to every in-range i, then read it back) -> every read matches, err=0, wr_count=32.
